// File: rtl/ifetch_unit_if.sv
// Instruction memory fetch bus: request/address from the fetch unit,
// ack/read data back from the memory.
interface ifetch_unit_if;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic        Imem_ack;
  logic [31:0] Imem_rdata;

  modport master (
    output Imem_req,
    output Imem_addr,
    input  Imem_ack,
    input  Imem_rdata
  );

  modport slave (
    input  Imem_req,
    input  Imem_addr,
    output Imem_ack,
    output Imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches over a req/ack bus and
// presents decoded instruction fields. Next PC is applied on retire.
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | request outstanding at Pc; IR captured on the ack edge
// EXEC  | IR live; retire (PC update, Retired++) on first cycle without Stall
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [1:0]          Pcsrc,
  input  logic                Stall,
  ifetch_unit_if.master       imem,
  output logic                Inst_valid,
  output logic [5:0]          Op,
  output logic [5:0]          Func,
  output logic [4:0]          Rs,
  output logic [4:0]          Rt,
  output logic [4:0]          Rd,
  output logic [15:0]         Imm,
  output logic [25:0]         Addr,
  output logic [31:0]         Pc,
  output logic [31:0]         Pc4,
  output logic [31:0]         Retired
);

  localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic {FETCH, EXEC} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, ir, retired, pc_nxt;
  logic        capture, retire;

  // State register; reset wins over any pending ack.
  always_ff @(posedge Clk) begin
    if (Rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next-state, handshake outputs and capture/retire strobes.
  always_comb begin
    state_nxt      = state;
    imem.Imem_req  = 1'b0;
    Inst_valid     = 1'b0;
    capture        = 1'b0;
    retire         = 1'b0;
    case (state)
      FETCH: begin
        imem.Imem_req = 1'b1;
        if (imem.Imem_ack) begin
          capture   = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        Inst_valid = 1'b1;
        if (!Stall) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
    if (Rst) begin
      imem.Imem_req = 1'b0;
      Inst_valid    = 1'b0;
      capture       = 1'b0;
      retire        = 1'b0;
    end
  end

  // Next-PC select; all candidates are word aligned by construction.
  always_comb begin
    pc_nxt = Pc4;
    case (Pcsrc)
      2'b10:   pc_nxt = Pc4 + {{14{ir[15]}}, ir[15:0], 2'b00};
      2'b11:   pc_nxt = {Pc4[31:28], ir[25:0], 2'b00};
      default: pc_nxt = Pc4;
    endcase
  end

  // PC, IR and retire counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc      <= PC_INIT;
      ir      <= 32'h0;
      retired <= 32'h0;
    end else begin
      if (capture) ir <= imem.Imem_rdata;
      if (retire) begin
        pc      <= {pc_nxt[31:2], 2'b00};
        retired <= retired + 32'd1;
      end
    end
  end

  assign imem.Imem_addr = pc;
  assign Pc      = pc;
  assign Pc4     = pc + 32'd4;
  assign Retired = retired;
  assign Op      = ir[31:26];
  assign Func    = ir[5:0];
  assign Rs      = ir[25:21];
  assign Rt      = ir[20:16];
  assign Rd      = ir[15:11];
  assign Imm     = ir[15:0];
  assign Addr    = ir[25:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: three instances with different reset PCs
// (0, top of address space, unaligned in the 0x1000_0000 region).
module tb_ifetch_unit;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  ifetch_unit_if a_if ();
  ifetch_unit_if b_if ();
  ifetch_unit_if c_if ();

  logic [1:0]  pcsrc_a, pcsrc_b, pcsrc_c;
  logic        stall_a, stall_b, stall_c;
  logic        valid_a, valid_b, valid_c;
  logic [5:0]  op_a, op_b, op_c, func_a, func_b, func_c;
  logic [4:0]  rs_a, rs_b, rs_c, rt_a, rt_b, rt_c, rd_a, rd_b, rd_c;
  logic [15:0] imm_a, imm_b, imm_c;
  logic [25:0] addr_a, addr_b, addr_c;
  logic [31:0] pc_a, pc_b, pc_c, pc4_a, pc4_b, pc4_c, ret_a, ret_b, ret_c;

  logic [31:0] mem_a [0:15];

  assign a_if.Imem_rdata = mem_a[a_if.Imem_addr[5:2]];
  assign b_if.Imem_rdata = 32'h0000_0000;
  assign c_if.Imem_rdata = 32'h0800_0040;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
    .Clk(Clk), .Rst(Rst), .Pcsrc(pcsrc_a), .Stall(stall_a), .imem(a_if.master),
    .Inst_valid(valid_a), .Op(op_a), .Func(func_a), .Rs(rs_a), .Rt(rt_a), .Rd(rd_a),
    .Imm(imm_a), .Addr(addr_a), .Pc(pc_a), .Pc4(pc4_a), .Retired(ret_a));

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .Clk(Clk), .Rst(Rst), .Pcsrc(pcsrc_b), .Stall(stall_b), .imem(b_if.master),
    .Inst_valid(valid_b), .Op(op_b), .Func(func_b), .Rs(rs_b), .Rt(rt_b), .Rd(rd_b),
    .Imm(imm_b), .Addr(addr_b), .Pc(pc_b), .Pc4(pc4_b), .Retired(ret_b));

  ifetch_unit #(.RESET_PC(32'h1000_0013)) dut_c (
    .Clk(Clk), .Rst(Rst), .Pcsrc(pcsrc_c), .Stall(stall_c), .imem(c_if.master),
    .Inst_valid(valid_c), .Op(op_c), .Func(func_c), .Rs(rs_c), .Rt(rt_c), .Rd(rd_c),
    .Imm(imm_c), .Addr(addr_c), .Pc(pc_c), .Pc4(pc4_c), .Retired(ret_c));

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    tests++; if (a_if.Imem_req !== 1'b0) begin fails++; $display("FAIL rst_req_a got %b want 0", a_if.Imem_req); end
    tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL rst_valid_a got %b want 0", valid_a); end
    tests++; if (pc_a !== 32'h0) begin fails++; $display("FAIL rst_pc_a got %h want 0", pc_a); end
    tests++; if (ret_a !== 32'h0) begin fails++; $display("FAIL rst_retired_a got %h want 0", ret_a); end
    tests++; if (op_a !== 6'h0) begin fails++; $display("FAIL rst_op_a got %h want 0", op_a); end
    tests++; if (pc_b !== 32'hFFFF_FFFC) begin fails++; $display("FAIL rst_pc_b got %h want fffffffc", pc_b); end
    tests++; if (pc_c !== 32'h1000_0010) begin fails++; $display("FAIL rst_pc_c_align got %h want 10000010", pc_c); end
    Rst = 1'b0;
    #1;
    tests++; if (a_if.Imem_req !== 1'b1) begin fails++; $display("FAIL first_req_a got %b want 1", a_if.Imem_req); end
    tests++; if (a_if.Imem_addr !== 32'h0) begin fails++; $display("FAIL first_addr_a got %h want 0", a_if.Imem_addr); end
    tests++; if (c_if.Imem_addr !== 32'h1000_0010) begin fails++; $display("FAIL first_addr_c got %h want 10000010", c_if.Imem_addr); end
  endtask

  task automatic test_basic();
    a_if.Imem_ack = 1'b1;
    tick();
    a_if.Imem_ack = 1'b0;
    tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", valid_a); end
    tests++; if (a_if.Imem_req !== 1'b0) begin fails++; $display("FAIL basic_req_exec got %b want 0", a_if.Imem_req); end
    tests++; if (op_a !== 6'h08) begin fails++; $display("FAIL basic_op got %h want 08", op_a); end
    tests++; if (rt_a !== 5'd1) begin fails++; $display("FAIL basic_rt got %h want 01", rt_a); end
    tests++; if (imm_a !== 16'h0005) begin fails++; $display("FAIL basic_imm got %h want 0005", imm_a); end
    pcsrc_a = 2'b00;
    tick();
    tests++; if (a_if.Imem_addr !== 32'h4) begin fails++; $display("FAIL basic_next_addr got %h want 4", a_if.Imem_addr); end
    tests++; if (ret_a !== 32'd1) begin fails++; $display("FAIL basic_retired got %0d want 1", ret_a); end
    tests++; if (a_if.Imem_req !== 1'b1) begin fails++; $display("FAIL basic_req_fetch got %b want 1", a_if.Imem_req); end
  endtask

  task automatic test_branch();
    a_if.Imem_ack = 1'b1;
    pcsrc_a = 2'b00;
    tick(); tick();
    tick();
    tests++; if (pc_a !== 32'h8) begin fails++; $display("FAIL br_pc got %h want 8", pc_a); end
    tests++; if (imm_a !== 16'hFFFE) begin fails++; $display("FAIL br_imm got %h want fffe", imm_a); end
    pcsrc_a = 2'b10;
    tick();
    tests++; if (a_if.Imem_addr !== 32'h4) begin fails++; $display("FAIL br_taken_addr got %h want 4", a_if.Imem_addr); end
    tests++; if (ret_a !== 32'd3) begin fails++; $display("FAIL br_retired got %0d want 3", ret_a); end
    pcsrc_a = 2'b00;
    tick(); tick();
    tick();
    pcsrc_a = 2'b01;
    tick();
    a_if.Imem_ack = 1'b0;
    tests++; if (a_if.Imem_addr !== 32'hC) begin fails++; $display("FAIL br_pcsrc01_addr got %h want c", a_if.Imem_addr); end
    tests++; if (ret_a !== 32'd5) begin fails++; $display("FAIL br_retired2 got %0d want 5", ret_a); end
  endtask

  task automatic test_stall();
    pcsrc_a = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (a_if.Imem_addr !== 32'hC || a_if.Imem_req !== 1'b1 || valid_a !== 1'b0) begin
        fails++; $display("FAIL wait_hold[%0d] got addr %h req %b valid %b want c 1 0", i, a_if.Imem_addr, a_if.Imem_req, valid_a);
      end
    end
    a_if.Imem_ack = 1'b1;
    tick();
    a_if.Imem_ack = 1'b0;
    tests++; if (valid_a !== 1'b1 || rd_a !== 5'd3) begin fails++; $display("FAIL stall_exec got valid %b rd %0d want 1 3", valid_a, rd_a); end
    stall_a = 1'b1;
    pcsrc_a = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (valid_a !== 1'b1 || pc_a !== 32'hC || ret_a !== 32'd5 || imm_a !== 16'h1820) begin
        fails++; $display("FAIL stall_hold[%0d] got valid %b pc %h ret %0d imm %h want 1 c 5 1820", i, valid_a, pc_a, ret_a, imm_a);
      end
      pcsrc_a = 2'b10;
    end
    stall_a = 1'b0;
    pcsrc_a = 2'b00;
    tick();
    tests++; if (a_if.Imem_addr !== 32'h10) begin fails++; $display("FAIL stall_retire_addr got %h want 10", a_if.Imem_addr); end
    tests++; if (ret_a !== 32'd6) begin fails++; $display("FAIL stall_retired got %0d want 6", ret_a); end
  endtask

  task automatic test_jump();
    c_if.Imem_ack = 1'b1;
    tick();
    c_if.Imem_ack = 1'b0;
    tests++; if (op_c !== 6'h02 || addr_c !== 26'h40) begin fails++; $display("FAIL jmp_fields got op %h addr %h want 02 0000040", op_c, addr_c); end
    pcsrc_c = 2'b11;
    tick();
    tests++; if (c_if.Imem_addr !== 32'h1000_0100) begin fails++; $display("FAIL jmp_addr got %h want 10000100", c_if.Imem_addr); end
    tests++; if (ret_c !== 32'd1) begin fails++; $display("FAIL jmp_retired got %0d want 1", ret_c); end
  endtask

  task automatic test_wrap();
    b_if.Imem_ack = 1'b1;
    tick();
    b_if.Imem_ack = 1'b0;
    tests++; if (pc4_b !== 32'h0) begin fails++; $display("FAIL wrap_pc4 got %h want 0", pc4_b); end
    pcsrc_b = 2'b00;
    tick();
    tests++; if (b_if.Imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr got %h want 0", b_if.Imem_addr); end
    tests++; if (ret_b !== 32'd1) begin fails++; $display("FAIL wrap_retired got %0d want 1", ret_b); end
  endtask

  task automatic test_rst_mid_fetch();
    a_if.Imem_ack = 1'b1;
    Rst = 1'b1;
    #1;
    tests++; if (a_if.Imem_req !== 1'b0) begin fails++; $display("FAIL midrst_req_gate got %b want 0", a_if.Imem_req); end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (valid_a !== 1'b0 || rd_a !== 5'd0 || op_a !== 6'd0 || pc_a !== 32'h0 || ret_a !== 32'h0 || a_if.Imem_req !== 1'b0) begin
        fails++; $display("FAIL midrst_state[%0d] got valid %b rd %0d op %h pc %h ret %0d req %b want 0 0 0 0 0 0",
                          i, valid_a, rd_a, op_a, pc_a, ret_a, a_if.Imem_req);
      end
    end
    Rst = 1'b0;
    a_if.Imem_ack = 1'b0;
    #1;
    tests++; if (a_if.Imem_req !== 1'b1 || a_if.Imem_addr !== 32'h0) begin fails++; $display("FAIL midrst_refetch got req %b addr %h want 1 0", a_if.Imem_req, a_if.Imem_addr); end
    a_if.Imem_ack = 1'b1;
    tick();
    a_if.Imem_ack = 1'b0;
    tests++; if (valid_a !== 1'b1 || op_a !== 6'h08 || ret_a !== 32'd0) begin fails++; $display("FAIL midrst_exec got valid %b op %h ret %0d want 1 08 0", valid_a, op_a, ret_a); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_a[i] = 32'h0;
    mem_a[0] = 32'h2001_0005;
    mem_a[2] = 32'h1000_FFFE;
    mem_a[3] = 32'h0022_1820;
    mem_a[4] = 32'h8C41_0004;
    Rst = 1'b1;
    a_if.Imem_ack = 1'b0; b_if.Imem_ack = 1'b0; c_if.Imem_ack = 1'b0;
    pcsrc_a = 2'b00; pcsrc_b = 2'b00; pcsrc_c = 2'b00;
    stall_a = 1'b0; stall_b = 1'b0; stall_c = 1'b0;
    tick(); tick();
    test_reset();
    test_basic();
    test_branch();
    test_stall();
    test_jump();
    test_wrap();
    test_rst_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
